// File: rtl/free_list_nway.sv
`default_nettype none
// ============================================================================
// Module   : free_list_nway
// Brief    : Multi-port physical-register free list with all-or-nothing grants
//            and single-cycle head restore for branch recovery.
// Revision : 1.0
// ============================================================================
module free_list_nway #(
  parameter int PRF_NUM   = 64,
  parameter int LRF_NUM   = 32,
  parameter int DISP_W    = 2,
  parameter int RET_W     = 2,
  parameter int ZERO_PREG = 31
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [DISP_W-1:0]                                disp_req_i,
  output logic                                             disp_ok_o,
  output logic [DISP_W*$clog2(PRF_NUM)-1:0]                free_preg_o,
  input  logic [RET_W-1:0]                                 retire_vld_i,
  input  logic [RET_W*$clog2(PRF_NUM)-1:0]                 retire_preg_i,
  input  logic                                             recover_i,
  input  logic [$clog2(PRF_NUM-LRF_NUM):0]                 recover_head_i,
  output logic [$clog2(PRF_NUM-LRF_NUM):0]                 head_nxt_o,
  output logic [$clog2(PRF_NUM-LRF_NUM):0]                 free_cnt_o,
  output logic                                             overflow_o
);

  localparam int PRF_IDX_W = $clog2(PRF_NUM);
  localparam int FL_NUM    = PRF_NUM - LRF_NUM;
  localparam int PTR_W     = $clog2(FL_NUM);
  localparam int PTR_FW    = PTR_W + 1;
  localparam int SUM_W     = PTR_W + 2;

  localparam logic [PRF_IDX_W-1:0] C_ZERO_PREG = PRF_IDX_W'(ZERO_PREG);
  localparam logic [PTR_W:0]       C_FL_NUM_P  = PTR_FW'(FL_NUM);
  localparam logic [SUM_W-1:0]     C_FL_NUM_S  = SUM_W'(FL_NUM);

  logic [PRF_IDX_W-1:0] r_fl [FL_NUM];
  logic [PTR_W:0]       r_head;
  logic [PTR_W:0]       r_tail;
  logic [PTR_W:0]       r_free_cnt;
  logic                 r_overflow;

  logic [PTR_W:0]       w_disp_off [DISP_W];
  logic [PTR_W:0]       w_disp_n;
  logic                 w_disp_ok;
  logic [PTR_W:0]       w_head_nxt;

  logic [RET_W-1:0]     w_ret_keep;
  logic [PTR_W-1:0]     w_ret_idx [RET_W];
  logic [PTR_W:0]       w_ret_m;
  logic [SUM_W-1:0]     w_ret_sum;
  logic                 w_ret_ovf;
  logic [PTR_W:0]       w_tail_nxt;
  logic [PTR_W:0]       w_rec_cnt;
  logic                 w_rec_ovf;
  logic [PTR_W:0]       w_cnt_nxt;

  // Each requesting slot reads at head plus the number of requesters below it.
  always_comb begin
    w_disp_n = '0;
    for (int k = 0; k < DISP_W; k++) begin
      w_disp_off[k] = w_disp_n;
      w_disp_n      = w_disp_n + PTR_FW'(disp_req_i[k]);
    end
  end

  assign w_disp_ok = ~recover_i & (w_disp_n <= r_free_cnt);

  for (genvar k = 0; k < DISP_W; k++) begin : g_disp_slot
    logic [PTR_W-1:0] w_idx;
    assign w_idx = r_head[PTR_W-1:0] + w_disp_off[k][PTR_W-1:0];
    assign free_preg_o[k*PRF_IDX_W +: PRF_IDX_W] = disp_req_i[k] ? r_fl[w_idx] : C_ZERO_PREG;
  end

  always_comb begin
    if (recover_i)
      w_head_nxt = recover_head_i;
    else if (w_disp_ok)
      w_head_nxt = r_head + w_disp_n;
    else
      w_head_nxt = r_head;
  end

  // Releases are compacted: only kept slots consume consecutive tail positions.
  always_comb begin
    w_ret_m = '0;
    for (int k = 0; k < RET_W; k++) begin
      w_ret_keep[k] = retire_vld_i[k] &
                      (retire_preg_i[k*PRF_IDX_W +: PRF_IDX_W] != C_ZERO_PREG);
      w_ret_idx[k]  = r_tail[PTR_W-1:0] + w_ret_m[PTR_W-1:0];
      w_ret_m       = w_ret_m + PTR_FW'(w_ret_keep[k]);
    end
  end

  assign w_ret_sum  = {1'b0, r_free_cnt} + {1'b0, w_ret_m};
  assign w_ret_ovf  = w_ret_sum > C_FL_NUM_S;
  assign w_tail_nxt = w_ret_ovf ? r_tail : (r_tail + w_ret_m);
  assign w_rec_cnt  = w_tail_nxt - recover_head_i;
  assign w_rec_ovf  = recover_i & (w_rec_cnt > C_FL_NUM_P);

  always_comb begin
    if (recover_i)
      w_cnt_nxt = w_rec_cnt;
    else
      w_cnt_nxt = r_free_cnt - (w_disp_ok ? w_disp_n : '0) + (w_ret_ovf ? '0 : w_ret_m);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= {1'b1, {PTR_W{1'b0}}};
      r_free_cnt <= C_FL_NUM_P;
      r_overflow <= 1'b0;
      for (int k = 0; k < FL_NUM; k++)
        r_fl[k] <= PRF_IDX_W'(LRF_NUM + k);
    end else begin
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_free_cnt <= w_cnt_nxt;
      if (w_ret_ovf | w_rec_ovf)
        r_overflow <= 1'b1;
      if (!w_ret_ovf) begin
        for (int k = 0; k < RET_W; k++)
          if (w_ret_keep[k])
            r_fl[w_ret_idx[k]] <= retire_preg_i[k*PRF_IDX_W +: PRF_IDX_W];
      end
    end
  end

  assign disp_ok_o  = w_disp_ok;
  assign head_nxt_o = w_head_nxt;
  assign free_cnt_o = r_free_cnt;
  assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_free_list_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list_nway
// Brief    : Directed self-checking bench for free_list_nway.
// Revision : 1.0
// ============================================================================
module tb_free_list_nway;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  disp_req_i = '0;
  logic        disp_ok_o;
  logic [11:0] free_preg_o;
  logic [1:0]  retire_vld_i = '0;
  logic [11:0] retire_preg_i = '0;
  logic        recover_i = 1'b0;
  logic [5:0]  recover_head_i = '0;
  logic [5:0]  head_nxt_o;
  logic [5:0]  free_cnt_o;
  logic        overflow_o;

  int n_chk = 0;
  int n_err = 0;
  int exp_cnt;
  logic [5:0] exp_q [$];
  logic [5:0] r_a, r_b;

  wire [5:0] w_slot0 = free_preg_o[5:0];
  wire [5:0] w_slot1 = free_preg_o[11:6];

  free_list_nway dut (
    .clk            (clk),
    .rst            (rst),
    .disp_req_i     (disp_req_i),
    .disp_ok_o      (disp_ok_o),
    .free_preg_o    (free_preg_o),
    .retire_vld_i   (retire_vld_i),
    .retire_preg_i  (retire_preg_i),
    .recover_i      (recover_i),
    .recover_head_i (recover_head_i),
    .head_nxt_o     (head_nxt_o),
    .free_cnt_o     (free_cnt_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    disp_req_i     = '0;
    retire_vld_i   = '0;
    retire_preg_i  = '0;
    recover_i      = 1'b0;
    recover_head_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic retire2(input logic [5:0] a, input logic [5:0] b);
    retire_vld_i  = 2'b11;
    retire_preg_i = {b, a};
  endtask

  initial begin
    idle();
    #12 rst = 1'b0;
    #1;
    check_val("rst_cnt", free_cnt_o, 32);
    check_val("rst_ovf", overflow_o, 0);
    check_val("rst_ok", disp_ok_o, 1);
    check_val("rst_head", head_nxt_o, 0);

    // basic allocation, then recovery with a concurrent release
    disp_req_i = 2'b11;
    #1;
    check_val("basic_ok", disp_ok_o, 1);
    check_val("basic_s0", w_slot0, 32);
    check_val("basic_s1", w_slot1, 33);
    check_val("basic_head", head_nxt_o, 2);
    tick();
    check_val("basic_cnt", free_cnt_o, 30);
    for (int i = 0; i < 3; i++) tick();
    check_val("pre_rec_head", head_nxt_o, 10);
    disp_req_i = 2'b00;
    #1;
    check_val("pre_rec_cnt", free_cnt_o, 24);
    recover_i      = 1'b1;
    recover_head_i = 6'd2;
    disp_req_i     = 2'b11;
    retire_vld_i   = 2'b01;
    retire_preg_i  = {6'd0, 6'd7};
    #1;
    check_val("rec_ok", disp_ok_o, 0);
    check_val("rec_head", head_nxt_o, 2);
    tick();
    idle();
    disp_req_i = 2'b01;
    #1;
    check_val("rec_cnt", free_cnt_o, 31);
    check_val("rec_s0", w_slot0, 34);

    // sparse request and release compaction
    do_reset();
    disp_req_i = 2'b10;
    #1;
    check_val("sparse_ok", disp_ok_o, 1);
    check_val("sparse_s0", w_slot0, 31);
    check_val("sparse_s1", w_slot1, 32);
    tick();
    idle();
    check_val("sparse_cnt", free_cnt_o, 31);
    retire2(6'd5, 6'd31);
    tick();
    idle();
    check_val("compact_cnt", free_cnt_o, 32);
    check_val("compact_ovf", overflow_o, 0);

    // drain, reject, release becomes visible next cycle
    do_reset();
    disp_req_i = 2'b11;
    for (int i = 0; i < 16; i++) tick();
    idle();
    check_val("drain_cnt", free_cnt_o, 0);
    disp_req_i    = 2'b01;
    retire_vld_i  = 2'b01;
    retire_preg_i = {6'd0, 6'd9};
    #1;
    check_val("reject_ok", disp_ok_o, 0);
    check_val("reject_head", head_nxt_o, 32);
    tick();
    retire_vld_i = '0;
    #1;
    check_val("refill_cnt", free_cnt_o, 1);
    check_val("refill_ok", disp_ok_o, 1);
    check_val("refill_s0", w_slot0, 9);
    tick();
    idle();
    check_val("refill_cnt2", free_cnt_o, 0);

    // wrap-around: offset the tail, drain, release 20..51 across index 31->0
    do_reset();
    disp_req_i = 2'b11;
    tick();
    tick();
    idle();
    retire2(6'd32, 6'd33);
    tick();
    retire2(6'd34, 6'd35);
    tick();
    idle();
    check_val("wrap_fill_cnt", free_cnt_o, 32);
    exp_cnt = 32;
    for (int j = 0; j < 16; j++) begin
      disp_req_i = 2'b11;
      #1;
      check_val("wrap_drain_s0", w_slot0, 32 + ((2*j + 4) % 32));
      check_val("wrap_drain_s1", w_slot1, 32 + ((2*j + 5) % 32));
      tick();
      exp_cnt -= 2;
      check_val("wrap_drain_cnt", free_cnt_o, exp_cnt);
    end
    idle();
    for (int j = 0; j < 16; j++) begin
      r_a = 6'(20 + 2*j);
      r_b = 6'(21 + 2*j);
      retire2(r_a, r_b);
      if (r_a != 6'd31) begin exp_q.push_back(r_a); exp_cnt++; end
      if (r_b != 6'd31) begin exp_q.push_back(r_b); exp_cnt++; end
      tick();
      check_val("wrap_rel_cnt", free_cnt_o, exp_cnt);
    end
    idle();
    while (exp_q.size() >= 2) begin
      disp_req_i = 2'b11;
      #1;
      r_a = exp_q.pop_front();
      r_b = exp_q.pop_front();
      check_val("wrap_alloc_s0", w_slot0, r_a);
      check_val("wrap_alloc_s1", w_slot1, r_b);
      tick();
      exp_cnt -= 2;
      check_val("wrap_alloc_cnt", free_cnt_o, exp_cnt);
    end
    disp_req_i = 2'b01;
    #1;
    r_a = exp_q.pop_front();
    check_val("wrap_last_s0", w_slot0, r_a);
    tick();
    idle();
    check_val("wrap_last_cnt", free_cnt_o, 0);

    // overflow when full, then asynchronous reset between edges
    do_reset();
    retire_vld_i  = 2'b01;
    retire_preg_i = {6'd0, 6'd5};
    tick();
    idle();
    check_val("ovf_set", overflow_o, 1);
    check_val("ovf_cnt", free_cnt_o, 32);
    disp_req_i = 2'b11;
    tick();
    idle();
    check_val("ovf_sticky", overflow_o, 1);
    check_val("ovf_alloc_cnt", free_cnt_o, 30);
    rst = 1'b1;
    #1;
    check_val("arst_cnt", free_cnt_o, 32);
    check_val("arst_ovf", overflow_o, 0);
    check_val("arst_head", head_nxt_o, 0);
    check_val("arst_ok", disp_ok_o, 1);
    rst = 1'b0;
    disp_req_i = 2'b01;
    #1;
    check_val("arst_s0", w_slot0, 32);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
